// File: rtl/lane_adder_pipe_if.sv
// Valid/ready stream bundle for lane_adder_pipe: input beat side and output sum side.
interface lane_adder_pipe_if #(
    parameter int unsigned W     = 8,
    parameter int unsigned LANES = 4
);
    logic                       in_valid;
    logic                       in_ready;
    logic [LANES*W-1:0]         in_a;
    logic [LANES*W-1:0]         in_b;
    logic                       in_acc;
    logic                       out_valid;
    logic                       out_ready;
    logic [LANES*(W+1)-1:0]     out_sum;

    modport master (
        output in_valid, in_a, in_b, in_acc, out_ready,
        input  in_ready, out_valid, out_sum
    );

    modport slave (
        input  in_valid, in_a, in_b, in_acc, out_ready,
        output in_ready, out_valid, out_sum
    );
endinterface

// File: rtl/lane_adder_pipe.sv
// Multi-lane pipelined adder with backpressure and per-lane saturating accumulators
// updated on each output handshake that carries an accumulate request.
module lane_adder_pipe #(
    parameter int unsigned W      = 8,
    parameter int unsigned LANES  = 4,
    parameter int unsigned STAGES = 2,
    parameter int unsigned ACC_W  = 12
) (
    input  logic                   clk,
    input  logic                   rst_n,
    lane_adder_pipe_if.slave       bus,
    input  logic                   clr_acc,
    output logic [LANES*ACC_W-1:0] acc,
    output logic [LANES-1:0]       ovf,
    output logic [15:0]            txn_cnt
);
    localparam int unsigned SW  = W + 1;
    localparam int unsigned AW1 = ACC_W + 1;

    logic [STAGES-1:0]     v_q, v_d;
    logic [STAGES-1:0]     accf_q, accf_d;
    logic [LANES*SW-1:0]   sums_q [STAGES];
    logic [LANES*SW-1:0]   sums_d [STAGES];
    logic [STAGES-1:0]     adv;
    logic                  all_v;
    logic                  in_ready;
    logic                  in_fire;
    logic                  out_fire;
    logic [LANES*SW-1:0]   new_sums;
    logic [LANES*ACC_W-1:0] acc_q, acc_d;
    logic [LANES-1:0]      ovf_q, ovf_d;
    logic [AW1-1:0]        acc_tmp;
    logic [15:0]           txn_cnt_q, txn_cnt_d;

    // A stage advances unless it and every stage after it are full while the sink stalls.
    always_comb begin
        all_v = 1'b1;
        adv   = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            all_v  = all_v & v_q[i];
            adv[i] = v_q[i] & (bus.out_ready | ~all_v);
        end
    end

    assign in_ready = ~v_q[0] | adv[0];
    assign in_fire  = bus.in_valid & in_ready;
    assign out_fire = adv[STAGES-1];

    always_comb begin
        new_sums = '0;
        for (int k = 0; k < LANES; k++) begin
            new_sums[k*SW +: SW] = SW'(bus.in_a[k*W +: W]) + SW'(bus.in_b[k*W +: W]);
        end
    end

    always_comb begin
        for (int i = 0; i < STAGES; i++) begin
            v_d[i]    = v_q[i] & ~adv[i];
            sums_d[i] = sums_q[i];
            accf_d[i] = accf_q[i];
        end
        if (in_fire) begin
            v_d[0]    = 1'b1;
            sums_d[0] = new_sums;
            accf_d[0] = bus.in_acc;
        end
        for (int i = 1; i < STAGES; i++) begin
            if (adv[i-1]) begin
                v_d[i]    = 1'b1;
                sums_d[i] = sums_q[i-1];
                accf_d[i] = accf_q[i-1];
            end
        end
    end

    // Clear is applied before the add so a coincident handshake starts from zero.
    always_comb begin
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        acc_tmp = '0;
        for (int k = 0; k < LANES; k++) begin
            if (clr_acc) begin
                acc_d[k*ACC_W +: ACC_W] = '0;
                ovf_d[k]                = 1'b0;
            end
            if (out_fire && accf_q[STAGES-1]) begin
                acc_tmp = {1'b0, acc_d[k*ACC_W +: ACC_W]}
                        + AW1'(sums_q[STAGES-1][k*SW +: SW]);
                if (acc_tmp[ACC_W]) begin
                    acc_d[k*ACC_W +: ACC_W] = '1;
                    ovf_d[k]                = 1'b1;
                end else begin
                    acc_d[k*ACC_W +: ACC_W] = acc_tmp[ACC_W-1:0];
                end
            end
        end
    end

    assign txn_cnt_d = txn_cnt_q + {15'd0, out_fire};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_q       <= '0;
            accf_q    <= '0;
            acc_q     <= '0;
            ovf_q     <= '0;
            txn_cnt_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                sums_q[i] <= '0;
            end
        end else begin
            v_q       <= v_d;
            accf_q    <= accf_d;
            acc_q     <= acc_d;
            ovf_q     <= ovf_d;
            txn_cnt_q <= txn_cnt_d;
            for (int i = 0; i < STAGES; i++) begin
                sums_q[i] <= sums_d[i];
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = v_q[STAGES-1];
    assign bus.out_sum   = sums_q[STAGES-1];
    assign acc           = acc_q;
    assign ovf           = ovf_q;
    assign txn_cnt       = txn_cnt_q;
endmodule
